// File: rtl/mic1_uart_mmio.sv
// Memory-mapped UART responder for the Mic-1 data bus: data/status decode,
// RX and TX byte FIFOs, and a start/busy engine that feeds uart_tx.
module mic1_uart_mmio #(
    parameter logic [31:0] DATA_ADDR   = 32'hFFFF_FFFD,
    parameter logic [31:0] STATUS_ADDR = 32'hFFFF_FFFC,
    parameter int          RX_DEPTH    = 8,
    parameter int          TX_DEPTH    = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata_mem,
    output logic [31:0] mem_rdata,
    output logic        hit,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_CW = RX_AW + 1;
    localparam int TX_CW = TX_AW + 1;
    localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);
    localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);
    localparam logic [RX_CW-1:0] RX_CNT_ONE  = RX_CW'(1);
    localparam logic [TX_CW-1:0] TX_CNT_ONE  = TX_CW'(1);
    localparam logic [RX_AW-1:0] RX_PTR_ONE  = RX_AW'(1);
    localparam logic [TX_AW-1:0] TX_PTR_ONE  = TX_AW'(1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DRAIN = 2'd2
    } tx_state_e;

    logic             hit_s, rd_acc_s, wr_acc_s, rd_data_s, rd_stat_s, wr_data_s;
    logic             unused_s;
    logic [31:0]      status_s;

    logic [7:0]       rx_mem_q [RX_DEPTH];
    logic [7:0]       rx_mem_d [RX_DEPTH];
    logic [RX_AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [RX_CW-1:0] rx_count_q, rx_count_d;
    logic             rx_empty_s, rx_full_s, rx_push_s, rx_pop_s, rx_ovr_set_s;
    logic             rx_ovr_q, rx_ovr_d;

    logic [7:0]       tx_mem_q [TX_DEPTH];
    logic [7:0]       tx_mem_d [TX_DEPTH];
    logic [TX_AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [TX_CW-1:0] tx_count_q, tx_count_d;
    logic             tx_empty_s, tx_full_s, tx_push_s, tx_pop_s, tx_drop_set_s;
    logic             tx_drop_q, tx_drop_d;

    tx_state_e        state_q, state_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             rd_sel_q, rd_sel_d;
    logic [31:0]      rd_word_q, rd_word_d;

    // Address decode and bus access qualification
    always_comb begin
        hit_s     = (mem_addr == DATA_ADDR) || (mem_addr == STATUS_ADDR);
        rd_acc_s  = en & mem_read & hit_s;
        wr_acc_s  = en & mem_write & hit_s;
        rd_data_s = rd_acc_s & (mem_addr == DATA_ADDR);
        rd_stat_s = rd_acc_s & (mem_addr == STATUS_ADDR);
        wr_data_s = wr_acc_s & (mem_addr == DATA_ADDR);
        unused_s  = ^mem_wdata[31:8];
    end

    // RX FIFO control: a same-cycle pop makes room for a push into a full FIFO
    always_comb begin
        rx_empty_s   = (rx_count_q == {RX_CW{1'b0}});
        rx_full_s    = (rx_count_q == RX_FULL_CNT);
        rx_pop_s     = rd_data_s & ~rx_empty_s;
        rx_push_s    = rx_done & (~rx_full_s | rx_pop_s);
        rx_ovr_set_s = rx_done & rx_full_s & ~rx_pop_s;
        rx_mem_d     = rx_mem_q;
        rx_mem_d[rx_wptr_q] = rx_push_s ? rx_data : rx_mem_q[rx_wptr_q];
        rx_wptr_d    = rx_push_s ? (rx_wptr_q + RX_PTR_ONE) : rx_wptr_q;
        rx_rptr_d    = rx_pop_s ? (rx_rptr_q + RX_PTR_ONE) : rx_rptr_q;
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_count_d = rx_count_q + RX_CNT_ONE;
            2'b01:   rx_count_d = rx_count_q - RX_CNT_ONE;
            default: rx_count_d = rx_count_q;
        endcase
        rx_ovr_d = rx_ovr_set_s ? 1'b1 : (rd_stat_s ? 1'b0 : rx_ovr_q);
    end

    // TX engine: launch the head byte, hold start until busy, then wait out the frame
    always_comb begin
        tx_empty_s = (tx_count_q == {TX_CW{1'b0}});
        state_d    = state_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        tx_pop_s   = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!tx_empty_s && !tx_busy) begin
                    tx_pop_s   = 1'b1;
                    tx_data_d  = tx_mem_q[tx_rptr_q];
                    tx_start_d = 1'b1;
                    state_d    = TX_START;
                end else begin
                    tx_start_d = 1'b0;
                    state_d    = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = TX_DRAIN;
                end else begin
                    tx_start_d = 1'b1;
                    state_d    = TX_START;
                end
            end
            TX_DRAIN: begin
                if (!tx_busy) begin
                    state_d = TX_IDLE;
                end else begin
                    state_d = TX_DRAIN;
                end
            end
            default: begin
                tx_start_d = 1'b0;
                state_d    = TX_IDLE;
            end
        endcase
    end

    // TX FIFO control: the engine's pop frees a slot for a same-cycle bus write
    always_comb begin
        tx_full_s     = (tx_count_q == TX_FULL_CNT);
        tx_push_s     = wr_data_s & (~tx_full_s | tx_pop_s);
        tx_drop_set_s = wr_data_s & tx_full_s & ~tx_pop_s;
        tx_mem_d      = tx_mem_q;
        tx_mem_d[tx_wptr_q] = tx_push_s ? mem_wdata[7:0] : tx_mem_q[tx_wptr_q];
        tx_wptr_d     = tx_push_s ? (tx_wptr_q + TX_PTR_ONE) : tx_wptr_q;
        tx_rptr_d     = tx_pop_s ? (tx_rptr_q + TX_PTR_ONE) : tx_rptr_q;
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_count_d = tx_count_q + TX_CNT_ONE;
            2'b01:   tx_count_d = tx_count_q - TX_CNT_ONE;
            default: tx_count_d = tx_count_q;
        endcase
        tx_drop_d = tx_drop_set_s ? 1'b1 : (rd_stat_s ? 1'b0 : tx_drop_q);
    end

    // Read response: status reflects the state before this cycle's updates
    always_comb begin
        status_s = {8'h00, 8'(tx_count_q), 8'(rx_count_q), 3'b000,
                    tx_busy, tx_drop_q, rx_ovr_q, tx_full_s, ~rx_empty_s};
        rd_sel_d = rd_acc_s;
        if (rd_stat_s) begin
            rd_word_d = status_s;
        end else if (rx_pop_s) begin
            rd_word_d = {24'h000000, rx_mem_q[rx_rptr_q]};
        end else begin
            rd_word_d = 32'h0000_0000;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= 8'h00;
            for (int i = 0; i < TX_DEPTH; i++) tx_mem_q[i] <= 8'h00;
            rx_wptr_q  <= {RX_AW{1'b0}};
            rx_rptr_q  <= {RX_AW{1'b0}};
            rx_count_q <= {RX_CW{1'b0}};
            rx_ovr_q   <= 1'b0;
            tx_wptr_q  <= {TX_AW{1'b0}};
            tx_rptr_q  <= {TX_AW{1'b0}};
            tx_count_q <= {TX_CW{1'b0}};
            tx_drop_q  <= 1'b0;
            state_q    <= TX_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            rd_sel_q   <= 1'b0;
            rd_word_q  <= 32'h0000_0000;
        end else begin
            rx_mem_q   <= rx_mem_d;
            tx_mem_q   <= tx_mem_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_count_q <= rx_count_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_count_q <= tx_count_d;
            tx_drop_q  <= tx_drop_d;
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            rd_sel_q   <= rd_sel_d;
            rd_word_q  <= rd_word_d;
        end
    end

    assign hit       = hit_s;
    assign mem_rdata = rd_sel_q ? rd_word_q : mem_rdata_mem;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_mic1_uart_mmio.sv
// Directed self-checking bench for mic1_uart_mmio with a small uart_tx busy model.
module tb_mic1_uart_mmio;

    localparam logic [31:0] DATA_ADDR   = 32'hFFFF_FFFD;
    localparam logic [31:0] STATUS_ADDR = 32'hFFFF_FFFC;
    localparam logic [31:0] IDLE_ADDR   = 32'h0000_0100;
    localparam logic [31:0] MEMV        = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        resetn, en, mem_read, mem_write, rx_done;
    logic [31:0] mem_addr, mem_wdata, mem_rdata_mem, mem_rdata;
    logic        hit, tx_start, tx_busy;
    logic [7:0]  rx_data, tx_data;
    logic        tx_busy_force, model_en, tx_busy_m;
    logic [1:0]  m_st;
    int          m_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    assign tx_busy = model_en ? tx_busy_m : tx_busy_force;

    mic1_uart_mmio dut (
        .clk(clk), .resetn(resetn), .en(en), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata_mem(mem_rdata_mem),
        .mem_rdata(mem_rdata), .hit(hit), .rx_done(rx_done), .rx_data(rx_data),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
    );

    // uart_tx model: busy rises 2 cycles after start and stays high 20 cycles
    always @(posedge clk) begin
        if (!model_en) begin
            m_st <= 2'd0; m_cnt <= 0; tx_busy_m <= 1'b0;
        end else begin
            case (m_st)
                2'd0: if (tx_start && !tx_busy_m) m_st <= 2'd1;
                2'd1: begin tx_busy_m <= 1'b1; m_st <= 2'd2; m_cnt <= 1; end
                2'd2: if (m_cnt == 20) begin tx_busy_m <= 1'b0; m_st <= 2'd0; end
                      else m_cnt <= m_cnt + 1;
                default: m_st <= 2'd0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        en = 1'b1; mem_read = 1'b1; mem_addr = a;
        tick();
        mem_read = 1'b0; mem_addr = IDLE_ADDR;
        d = mem_rdata;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] wd, output logic wen);
        en = 1'b1; mem_write = 1'b1; mem_addr = a; mem_wdata = wd;
        #1 wen = en & mem_write & ~hit;
        @(posedge clk); #1;
        mem_write = 1'b0; mem_addr = IDLE_ADDR;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        rx_done = 1'b1; rx_data = b;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        resetn = 1'b0; en = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_addr = IDLE_ADDR;
        mem_wdata = 32'h0; mem_rdata_mem = MEMV; rx_done = 1'b0; rx_data = 8'h00;
        tx_busy_force = 1'b0; model_en = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        n_checks++; if (mem_rdata !== MEMV) begin n_fail++; $display("FAIL reset_passthru got=%h exp=%h", mem_rdata, MEMV); end
        n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL hit_other got=%b exp=0", hit); end
        mem_addr = STATUS_ADDR; #1;
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL hit_status got=%b exp=1", hit); end
        mem_addr = DATA_ADDR; #1;
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL hit_data got=%b exp=1", hit); end
        mem_addr = 32'hFFFF_FFFE; #1;
        n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL hit_near got=%b exp=0", hit); end
        mem_addr = IDLE_ADDR;
        bus_read(STATUS_ADDR, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status got=%h exp=00000000", d); end
    endtask

    task automatic test_rx_basic();
        logic [31:0] d;
        rx_pulse(8'h41); rx_pulse(8'h42); rx_pulse(8'h43);
        bus_read(STATUS_ADDR, d);
        n_checks++; if (d !== 32'h0000_0301) begin n_fail++; $display("FAIL rx_status got=%h exp=00000301", d); end
        for (int i = 0; i < 3; i++) begin
            bus_read(DATA_ADDR, d);
            n_checks++; if (d !== 32'h41 + i) begin n_fail++; $display("FAIL rx_data[%0d] got=%h exp=%h", i, d, 32'h41 + i); end
        end
        tick();
        n_checks++; if (mem_rdata !== MEMV) begin n_fail++; $display("FAIL rx_sel_drop got=%h exp=%h", mem_rdata, MEMV); end
        bus_read(DATA_ADDR, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rx_empty_read got=%h exp=00000000", d); end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d;
        for (int i = 0; i < 9; i++) rx_pulse(8'h10 + 8'(i));
        bus_read(STATUS_ADDR, d);
        n_checks++; if (d !== 32'h0000_0805) begin n_fail++; $display("FAIL ovr_status got=%h exp=00000805", d); end
        bus_read(STATUS_ADDR, d);
        n_checks++; if (d !== 32'h0000_0801) begin n_fail++; $display("FAIL ovr_clear got=%h exp=00000801", d); end
        for (int i = 0; i < 8; i++) begin
            bus_read(DATA_ADDR, d);
            n_checks++; if (d !== 32'h10 + i) begin n_fail++; $display("FAIL ovr_data[%0d] got=%h exp=%h", i, d, 32'h10 + i); end
        end
        bus_read(DATA_ADDR, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL ovr_lost got=%h exp=00000000", d); end
    endtask

    task automatic test_rx_full_pop();
        logic [31:0] d;
        for (int i = 0; i < 8; i++) rx_pulse(8'h20 + 8'(i));
        rx_done = 1'b1; rx_data = 8'h55;
        en = 1'b1; mem_read = 1'b1; mem_addr = DATA_ADDR;
        tick();
        rx_done = 1'b0; mem_read = 1'b0; mem_addr = IDLE_ADDR;
        d = mem_rdata;
        n_checks++; if (d !== 32'h20) begin n_fail++; $display("FAIL fullpop_data got=%h exp=00000020", d); end
        bus_read(STATUS_ADDR, d);
        n_checks++; if (d !== 32'h0000_0801) begin n_fail++; $display("FAIL fullpop_status got=%h exp=00000801", d); end
        for (int i = 0; i < 7; i++) begin
            bus_read(DATA_ADDR, d);
            n_checks++; if (d !== 32'h21 + i) begin n_fail++; $display("FAIL fullpop_data[%0d] got=%h exp=%h", i, d, 32'h21 + i); end
        end
        bus_read(DATA_ADDR, d);
        n_checks++; if (d !== 32'h55) begin n_fail++; $display("FAIL fullpop_last got=%h exp=00000055", d); end
        bus_read(STATUS_ADDR, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL fullpop_empty got=%h exp=00000000", d); end
    endtask

    task automatic test_tx_order();
        logic       wen, prev_start, prev_busy, hold_bad;
        logic [7:0] prev_data;
        logic [7:0] sdata [2];
        logic       sbusy [2];
        int         nstarts;
        model_en = 1'b1;
        bus_write(DATA_ADDR, 32'h48, wen);
        bus_write(DATA_ADDR, 32'h49, wen);
        prev_start = 1'b0; prev_busy = 1'b0; prev_data = 8'h00; hold_bad = 1'b0; nstarts = 0;
        sdata[0] = 8'h00; sdata[1] = 8'h00; sbusy[0] = 1'b1; sbusy[1] = 1'b1;
        for (int c = 0; c < 120; c++) begin
            if (tx_start && !prev_start) begin
                if (nstarts < 2) begin sdata[nstarts] = tx_data; sbusy[nstarts] = tx_busy; end
                nstarts++;
            end
            if (tx_start && prev_start && tx_data !== prev_data) hold_bad = 1'b1;
            if (tx_start && prev_start && tx_busy && prev_busy) hold_bad = 1'b1;
            if (!tx_start && prev_start && !prev_busy) hold_bad = 1'b1;
            prev_start = tx_start; prev_busy = tx_busy; prev_data = tx_data;
            tick();
        end
        n_checks++; if (nstarts !== 2) begin n_fail++; $display("FAIL tx_starts got=%0d exp=2", nstarts); end
        n_checks++; if (sdata[0] !== 8'h48) begin n_fail++; $display("FAIL tx_first got=%h exp=48", sdata[0]); end
        n_checks++; if (sdata[1] !== 8'h49) begin n_fail++; $display("FAIL tx_second got=%h exp=49", sdata[1]); end
        n_checks++; if (sbusy[1] !== 1'b0) begin n_fail++; $display("FAIL tx_second_busy got=%b exp=0", sbusy[1]); end
        n_checks++; if (hold_bad !== 1'b0) begin n_fail++; $display("FAIL tx_handshake got=%b exp=0", hold_bad); end
        model_en = 1'b0;
        tick(); tick();
    endtask

    task automatic test_en_gate();
        logic [31:0] d;
        rx_pulse(8'h77); rx_pulse(8'h78);
        en = 1'b0; mem_read = 1'b1; mem_addr = DATA_ADDR;
        tick();
        mem_read = 1'b0; mem_addr = IDLE_ADDR;
        n_checks++; if (mem_rdata !== MEMV) begin n_fail++; $display("FAIL en0_rdata got=%h exp=%h", mem_rdata, MEMV); end
        bus_read(STATUS_ADDR, d);
        n_checks++; if (d !== 32'h0000_0201) begin n_fail++; $display("FAIL en0_status got=%h exp=00000201", d); end
        bus_read(DATA_ADDR, d);
        n_checks++; if (d !== 32'h77) begin n_fail++; $display("FAIL en0_head got=%h exp=00000077", d); end
    endtask

    task automatic test_tx_full();
        logic [31:0] d;
        logic        wen;
        tx_busy_force = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus_write(DATA_ADDR, 32'hABCD_0060 + i, wen);
            n_checks++; if (wen !== 1'b0) begin n_fail++; $display("FAIL mem_wen[%0d] got=%b exp=0", i, wen); end
        end
        bus_read(STATUS_ADDR, d);
        n_checks++; if (d !== 32'h0008_011B) begin n_fail++; $display("FAIL txfull_status got=%h exp=0008011b", d); end
        bus_read(STATUS_ADDR, d);
        n_checks++; if (d !== 32'h0008_0113) begin n_fail++; $display("FAIL txfull_clear got=%h exp=00080113", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        tx_busy_force = 1'b0;
        tick();
        n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL mid_start got=%b exp=1", tx_start); end
        n_checks++; if (tx_data !== 8'h60) begin n_fail++; $display("FAIL mid_data got=%h exp=60", tx_data); end
        tx_busy_force = 1'b1;
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start got=%b exp=0", tx_start); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
        n_checks++; if (mem_rdata !== MEMV) begin n_fail++; $display("FAIL rst_passthru got=%h exp=%h", mem_rdata, MEMV); end
        bus_read(STATUS_ADDR, d);
        n_checks++; if (d !== 32'h0000_0010) begin n_fail++; $display("FAIL rst_status got=%h exp=00000010", d); end
        bus_read(DATA_ADDR, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_rx_empty got=%h exp=00000000", d); end
        tx_busy_force = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_tx_empty got=%b exp=0", tx_start); end
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_rx_overrun();
        test_rx_full_pop();
        test_tx_order();
        test_en_gate();
        test_tx_full();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
